pp2v_layer_compositor: RTL
==========================

// Module: pp2v_layer_compositor
// PURPOSE
//  Pipelined, run-time-programmable successor to the fixed PowerPoint-to-Verilog drawing controller.
//  Composites N_LAYERS rectangles, each opaque or 50% blended and each with an optional border,
//  over a constant background, then draws a mouse cursor on top.
//  Sits between the VGA timing generator (xPixel/yPixel) and the DAC outputs.
//  The layer table is double-buffered and written through a config port; it commits at frame start.
// PARAMETERS
//  N_LAYERS     8          number of rectangle layers; layer 0 is bottom, layer N_LAYERS-1 is top
//  X_W          10         width of xPixel and of the x fields
//  Y_W          9          width of yPixel and of the y fields
//  CURSOR_SIZE  20         cursor square span; interior is mouse+1 .. mouse+CURSOR_SIZE-1
//  BG_RGB       24'h192D0A background colour as {R,G,B}
//  AW           $clog2(N_LAYERS)  layer address width (localparam)
// PORTS
//  clk         in   1    pixel clock
//  reset       in   1    synchronous, active-high
//  xPixel      in   X_W  current pixel column
//  yPixel      in   Y_W  current pixel row
//  pixelValid  in   1    1 = active video; 0 = blanking
//  frameStart  in   1    1-cycle pulse before the first pixel; commits shadow table to active table
//  cfgWe       in   1    config write request
//  cfgReady    out  1    config write accepted when cfgWe && cfgReady
//  cfgAddr     in   AW   layer index
//  cfgField    in   4    field select (see BEHAVIOUR)
//  cfgData     in   16   field value (LSB-aligned)
//  mouseX      in   11   cursor origin x
//  mouseY      in   11   cursor origin y
//  VGAr        out  8    red
//  VGAg        out  8    green
//  VGAb        out  8    blue
//  outValid    out  1    pixelValid delayed by 2 cycles
// BEHAVIOUR
//  Reset: every layer in both tables has mode=0 (off) and all fields cleared;
//   VGAr/VGAg/VGAb=0; outValid=0; pipeline valid bits cleared; cfgReady=1 in the cycle after reset.
//  Config fields: 0 x0 | 1 x1 | 2 y0 | 3 y1 | 4 {R,G} | 5 B (low 8 bits) |
//   6 {mode[1:0]@[6:5], bBlend@[4], bW[3:0]@[3:0]} | 7 border {R,G} | 8 border B.
//   Fields 9-15 are accepted and ignored. cfgAddr >= N_LAYERS: write ignored.
//  mode: 0 off, 1 opaque, 2 50% blend, 3 reserved (treated as off).
//  Handshake: cfgReady=0 only in the frameStart cycle. A cfgWe in that cycle is dropped, not queued.
//   An accepted write lands in the shadow table in the next cycle.
//  Commit: on frameStart the active table takes a full-table copy of the shadow table.
//   The active table never changes mid-frame.
//  Hit test, unsigned, widened by 1 bit so there is no wrap: x>x0 && x<x1 && y>y0 && y<y1.
//   x1<=x0+1 or y1<=y0+1 never hits.
//  Border pixel: hit && (x<=x0+bW || x>=x1-bW || y<=y0+bW || y>=y1-bW); bW=0 means no border.
//   Border colour is opaque, or a 50% blend with the fill when bBlend=1.
//  Blend: out = (layer + below) >> 1 per channel, with a 9-bit sum, truncated. "below" is the
//   composite of all lower layers and the background.
//  Pipeline: stage 1 registers coords, valid and per-layer hit/border bits plus cursor hit.
//   Stage 2 folds the layers 0..N-1 in order, applies the cursor, and registers the outputs.
//   Latency is exactly 2 clocks, throughput 1 pixel/clock, no stalls.
//  pixelValid=0 at stage 2: RGB outputs are driven to 0 (blanking), outValid=0.
//  Cursor hit: x>mouseX && x<mouseX+CURSOR_SIZE (12-bit compare), same for y; cursor pixel is 0xFFFFFF.
//  frameStart coincident with pixelValid: the pixel in that cycle uses the new table.
//  Reset mid-frame: the pipeline is flushed and the tables are cleared; output is blank until new pixels arrive.
// CONFIGURATION
//  PP2V_CURSOR_EN defined: cursor drawn as above.
//  PP2V_CURSOR_EN undefined: mouseX/mouseY ignored, no cursor logic; latency unchanged (2 clocks).
// TESTING
//  Reset, then a 640x480 sweep with no config -> every valid pixel = 19/2D/0A; blanking pixels = 0; outValid lags by 2.
//  Layer0 {x0=53,x1=639,y0=385,y1=479,AFABAB, mode1, bW=1, border 2F528F}, commit
//   -> (54,386)=2F528F, (100,400)=AFABAB, (53,400)=bg.
//  Layer1 50% 404040 over layer0 overlap -> (AFABAB+404040)>>1 = 77/75/75; outside layer0 -> (bg+40)>>1 = 2C/36/25.
//  Write layer2 mode1 mid-frame -> unchanged until frameStart; cfgWe on the frameStart cycle -> cfgReady=0, write absent next frame.
//  mouse=(100,100), PP2V_CURSOR_EN defined -> (101..119,101..119) white, (100,100) not white;
//   undefined -> no white pixels.
//  Degenerate x1=x0+1; x1=1023 with bW=15; reset asserted mid-line -> no hit, no wrap, outputs 0 next cycle.

Source files
------------

// File: rtl/pp2v_layer_compositor.sv
// Two-stage layer compositor: N_LAYERS programmable rectangles over a constant background,
// with a double-buffered layer table. Optional mouse cursor is enabled by defining PP2V_CURSOR_EN.
module pp2v_layer_compositor #(
  parameter int          N_LAYERS    = 8,
  parameter int          X_W         = 10,
  parameter int          Y_W         = 9,
  parameter int          CURSOR_SIZE = 20,
  parameter logic [23:0] BG_RGB      = 24'h192D0A,
  localparam int         AW          = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] xPixel,
  input  logic [Y_W-1:0] yPixel,
  input  logic           pixelValid,
  input  logic           frameStart,
  input  logic           cfgWe,
  output logic           cfgReady,
  input  logic [AW-1:0]  cfgAddr,
  input  logic [3:0]     cfgField,
  input  logic [15:0]    cfgData,
  input  logic [10:0]    mouseX,
  input  logic [10:0]    mouseY,
  output logic [7:0]     VGAr,
  output logic [7:0]     VGAg,
  output logic [7:0]     VGAb,
  output logic           outValid
);

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic [23:0]    fill;
    logic [23:0]    bcol;
    logic [1:0]     mode;
    logic           bblend;
    logic [3:0]     bw;
  } layer_t;

  layer_t shadow [N_LAYERS];
  layer_t active [N_LAYERS];

  logic cfg_acc;
  assign cfgReady = ~frameStart;
  assign cfg_acc  = cfgWe & cfgReady & (int'(cfgAddr) < N_LAYERS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_LAYERS; i++) shadow[i] <= '0;
    end else if (cfg_acc) begin
      case (cfgField)
        4'd0: shadow[cfgAddr].x0         <= cfgData[X_W-1:0];
        4'd1: shadow[cfgAddr].x1         <= cfgData[X_W-1:0];
        4'd2: shadow[cfgAddr].y0         <= cfgData[Y_W-1:0];
        4'd3: shadow[cfgAddr].y1         <= cfgData[Y_W-1:0];
        4'd4: shadow[cfgAddr].fill[23:8] <= cfgData;
        4'd5: shadow[cfgAddr].fill[7:0]  <= cfgData[7:0];
        4'd6: begin
          shadow[cfgAddr].mode   <= cfgData[6:5];
          shadow[cfgAddr].bblend <= cfgData[4];
          shadow[cfgAddr].bw     <= cfgData[3:0];
        end
        4'd7: shadow[cfgAddr].bcol[23:8] <= cfgData;
        4'd8: shadow[cfgAddr].bcol[7:0]  <= cfgData[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_LAYERS; i++) active[i] <= '0;
    end else if (frameStart) begin
      active <= shadow;
    end
  end

  // Stage 1 sees the shadow table during frameStart so that pixel already uses the committed
  // geometry; stage 2 reads the active table, which has been updated by then.
  layer_t              e;
  logic [X_W:0]        xw, yw_dummy_unused;
  logic [Y_W:0]        yw;
  logic [N_LAYERS-1:0] hit_d, brd_d;
  logic                cur_d;

  assign xw = {1'b0, xPixel};
  assign yw = {1'b0, yPixel};
  assign yw_dummy_unused = '0;

  always_comb begin
    e     = '0;
    hit_d = '0;
    brd_d = '0;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      e = frameStart ? shadow[i] : active[i];
      hit_d[i] = (xw > {1'b0, e.x0}) && (xw < {1'b0, e.x1}) &&
                 (yw > {1'b0, e.y0}) && (yw < {1'b0, e.y1});
      // x >= x1-bW is evaluated as x+bW >= x1 so a wide border never underflows.
      brd_d[i] = hit_d[i] && (e.bw != 4'd0) &&
                 ((xw <= {1'b0, e.x0} + (X_W+1)'(e.bw)) ||
                  (xw + (X_W+1)'(e.bw) >= {1'b0, e.x1}) ||
                  (yw <= {1'b0, e.y0} + (Y_W+1)'(e.bw)) ||
                  (yw + (Y_W+1)'(e.bw) >= {1'b0, e.y1}));
    end
  end

`ifdef PP2V_CURSOR_EN
  logic [11:0] cx, cy, mx, my;
  assign cx    = 12'(xPixel);
  assign cy    = 12'(yPixel);
  assign mx    = {1'b0, mouseX};
  assign my    = {1'b0, mouseY};
  assign cur_d = (cx > mx) && (cx < mx + 12'(CURSOR_SIZE)) &&
                 (cy > my) && (cy < my + 12'(CURSOR_SIZE));
`else
  logic unused_mouse;
  assign unused_mouse = &{1'b0, mouseX, mouseY};
  assign cur_d        = 1'b0;
`endif

  logic                v1, cur1;
  logic [N_LAYERS-1:0] hit1, brd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      cur1 <= 1'b0;
      hit1 <= '0;
      brd1 <= '0;
    end else begin
      v1   <= pixelValid;
      cur1 <= cur_d;
      hit1 <= hit_d;
      brd1 <= brd_d;
    end
  end

  function automatic logic [23:0] avg(input logic [23:0] a, input logic [23:0] b);
    logic [8:0] sr, sg, sb;
    sr = {1'b0, a[23:16]} + {1'b0, b[23:16]};
    sg = {1'b0, a[15:8]}  + {1'b0, b[15:8]};
    sb = {1'b0, a[7:0]}   + {1'b0, b[7:0]};
    return {sr[8:1], sg[8:1], sb[8:1]};
  endfunction

  logic [23:0] comp, col;

  always_comb begin
    comp = BG_RGB;
    col  = '0;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (hit1[i] && (active[i].mode == 2'd1 || active[i].mode == 2'd2)) begin
        if (brd1[i])
          col = active[i].bblend ? avg(active[i].bcol, active[i].fill) : active[i].bcol;
        else
          col = active[i].fill;
        comp = (active[i].mode == 2'd1) ? col : avg(col, comp);
      end
    end
    if (cur1) comp = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {VGAr, VGAg, VGAb} <= '0;
      outValid           <= 1'b0;
    end else begin
      {VGAr, VGAg, VGAb} <= v1 ? comp : '0;
      outValid           <= v1;
    end
  end

endmodule
